pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline. Sits beside the forwarding unit and drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM.
- Resolves three hazard classes:
  - load-use data hazards that forwarding cannot cover;
  - taken-branch control hazards resolved in EX;
  - multi-cycle data-memory accesses, using a req/ready handshake.
- Keeps a small FSM (RUN / MEM_WAIT / HALT) for memory waits and timeout, plus saturating performance counters.

Parameters:
- CNT_W, 16, width of the stall/flush performance counters.
- MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before HALT. Must be ≥1.
- TO_W, 8, width of the timeout counter. Must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- rs1_ID  in  5  rs1 of the instruction in ID
- rs2_ID  in  5  rs2 of the instruction in ID
- uses_rs2_ID  in  1  ID instruction reads rs2 (R/S/B types)
- rd_EX  in  5  destination of the instruction in EX
- MemRead_EX  in  1  EX instruction is a load
- branch_taken_EX  in  1  EX resolved a taken branch/jump this cycle
- mem_req_MEM  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC update enable
- IFID_Write  out  1  IF/ID register enable
- IFID_Flush  out  1  IF/ID becomes NOP
- IDEX_Write  out  1  ID/EX register enable
- IDEX_Flush  out  1  ID/EX becomes bubble (control bits zero)
- EXMEM_Write  out  1  EX/MEM register enable
- halted  out  1  sticky memory-timeout error
- stall_cycles  out  CNT_W  cycles with PCWrite=0, saturating
- flush_events  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. During and after reset:
  - state=RUN, timeout counter=0, counters=0, halted=0.
  - Outputs while rst=1: all Write=1, all Flush=0.
- Control outputs are combinational (Mealy) from state and inputs, and act in the same cycle. Counters and state update on clk.
- load_use = MemRead_EX && rd_EX!=0 && (rd_EX==rs1_ID || (uses_rs2_ID && rd_EX==rs2_ID)).
- mem_stall = mem_req_MEM && !mem_ready.
- Priority, highest first: HALT > mem_stall > branch_taken_EX > load_use > normal.
- RUN state:
  - mem_stall: all four Write=0, both Flush=0. Next state MEM_WAIT, timeout counter=1.
  - branch_taken_EX: IFID_Flush=1, IDEX_Flush=1, all Write=1. flush_events++.
  - Branch and load_use together: branch wins; no stall cycle.
  - load_use: PCWrite=0, IFID_Write=0, IDEX_Flush=1, EXMEM_Write=1. Exactly one bubble, because next cycle the load is in MEM and the forwarding unit covers it.
  - Otherwise: all Write=1, all Flush=0.
- MEM_WAIT state:
  - Outputs: all Write=0, both Flush=0. branch_taken_EX and load_use are ignored; their inputs are held frozen and re-evaluated after the wait.
  - mem_ready=1: outputs behave exactly as RUN for this cycle (pipeline advances). Next state RUN.
  - mem_ready=0 and timeout counter==MEM_TIMEOUT: next state HALT, halted<=1.
  - mem_ready=0 otherwise: timeout counter++.
  - mem_req_MEM dropping without ready: treated as ready.
- HALT state: all Write=0, both Flush=0, halted=1. Exit only via rst.
- stall_cycles increments on every clk where PCWrite=0 and rst=0, including HALT. It saturates at 2^CNT_W−1 and never wraps. flush_events saturates the same way.
- Reset mid-wait: returns to RUN the next edge. Any outstanding memory access is the memory's responsibility.

Decomposition:
- Shared package hazard_pkg:
  - state encoding: RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2;
  - constant REG_ZERO=5'd0;
  - localparam for counter saturation.
- One natural sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count). Instantiated twice.
- The FSM and hazard logic stay in the top level.

Test Plan:
1. Load-use: MemRead_EX=1, rd_EX=5, rs1_ID=5, no mem_req. → PCWrite=0, IFID_Write=0, IDEX_Flush=1 for exactly 1 cycle. stall_cycles=1.
2. Load-use on rs2 with uses_rs2_ID=0 (rd_EX=7, rs2_ID=7); also rd_EX=0 with rs1_ID=0. → no stall in either case, all Write=1.
3. Branch with simultaneous load-use: branch_taken_EX=1 plus a load-use match. → IFID_Flush=IDEX_Flush=1, PCWrite=1, flush_events=1, stall_cycles=0.
4. Memory wait: mem_req_MEM=1, mem_ready=0 for 3 cycles, then 1. → all Write=0 for 3 cycles, advance on the 4th, state back to RUN. stall_cycles=3.
5. Timeout with MEM_TIMEOUT=4: mem_ready held 0. → halted=1 after 4 wait cycles, outputs frozen, stall_cycles keeps counting. rst=1 for 1 cycle clears everything.
6. Saturation with CNT_W=3: hold a memory stall for 10 cycles. → stall_cycles stops at 7 and does not wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO        = 5'd0;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;
    localparam int unsigned TO_W_DEF        = 8;

    // Counters stop at the all-ones value of their width and never wrap.
    localparam bit          CNT_SATURATE    = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter
    import hazard_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] SAT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !(CNT_SATURATE && (count_q == SAT_MAX))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes and multi-cycle data-memory waits with timeout.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned TO_W        = TO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             uses_rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Flush,
    output logic             EXMEM_Write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [TO_W-1:0] TIMEOUT = TO_W'(MEM_TIMEOUT);

    hz_state_e       state_q;
    hz_state_e       state_d;
    logic [TO_W-1:0] tcnt_q;
    logic [TO_W-1:0] tcnt_d;
    logic            halted_q;
    logic            halted_d;

    logic            load_use;
    logic            mem_stall;
    logic            stall_inc;
    logic            flush_inc;

    always_comb begin
        load_use  = MemRead_EX && (rd_EX != REG_ZERO) &&
                    ((rd_EX == rs1_ID) || (uses_rs2_ID && (rd_EX == rs2_ID)));
        mem_stall = mem_req_MEM && !mem_ready;
    end

    // Next state and Mealy controls; a MEM_WAIT cycle without a stall behaves as RUN.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        halted_d    = halted_q;
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Write  = 1'b1;
        IDEX_Flush  = 1'b0;
        EXMEM_Write = 1'b1;

        if (!rst) begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    if (mem_stall) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Write  = 1'b0;
                        EXMEM_Write = 1'b0;
                        if (state_q == RUN) begin
                            state_d = MEM_WAIT;
                            tcnt_d  = TO_W'(1);
                        end else if (tcnt_q == TIMEOUT) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end else begin
                            tcnt_d = tcnt_q + TO_W'(1);
                        end
                    end else begin
                        state_d = RUN;
                        if (branch_taken_EX) begin
                            IFID_Flush = 1'b1;
                            IDEX_Flush = 1'b1;
                        end else if (load_use) begin
                            PCWrite    = 1'b0;
                            IFID_Write = 1'b0;
                            IDEX_Flush = 1'b1;
                        end
                    end
                end
                HALT: begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Write  = 1'b0;
                    EXMEM_Write = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            tcnt_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;

    // Only a taken branch raises IFID_Flush, so it doubles as the flush event.
    always_comb begin
        stall_inc = !rst && !PCWrite;
        flush_inc = !rst && IFID_Flush;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_events)
    );

endmodule
